sram_like_slave: RTL and testbench

SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

---
 rtl/sram_like_slave_if.sv | 22 ++
 rtl/sram_like_slave.sv | 76 +++++++
 tb/tb_sram_like_slave.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_slave_if.sv
// Request/response bundle between a core and the SRAM-like slave.
interface sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_slave.sv
// SRAM-like slave: word memory with fixed-latency, in-order responses and
// a bounded number of outstanding requests.
module sram_like_slave #(
  parameter int ADDR_W      = 12,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input logic             clk,
  input logic             reset,
  sram_like_slave_if.slave bus
);
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  OUT_LIM = 4'(OUTSTANDING);

  logic [31:0]        mem_q [DEPTH];
  logic [3:0]         pend_q, pend_d;
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] rd_q;
  logic [31:0]        data_q [LATENCY];
  logic [ADDR_W-1:0]  idx;
  logic [31:0]        rd_word;
  logic               accept;
  logic               leave;
  logic               unused_bits;

  assign unused_bits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  assign idx          = bus.addr[ADDR_W+1:2];
  assign rd_word      = mem_q[idx];
  assign bus.addr_ok  = !reset && (pend_q < OUT_LIM);
  assign accept       = bus.req && bus.addr_ok;

  // A request stops counting as pending once it reaches the output stage,
  // so addr_ok reopens in the same cycle its data_ok is shown.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign leave = accept;
    end else begin : g_latn
      assign leave = vld_q[LATENCY-2];
    end
  endgenerate

  assign pend_d = pend_q + {3'b000, accept} - {3'b000, leave};

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      vld_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      vld_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    rd_q[0]   <= !bus.wr;
    data_q[0] <= bus.wr ? 32'h0 : rd_word;
    for (int i = 1; i < LATENCY; i++) begin
      rd_q[i]   <= rd_q[i-1];
      data_q[i] <= data_q[i-1];
    end
  end

  // Memory is deliberately outside reset so accepted writes survive it.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.data_ok = vld_q[LATENCY-1] && !reset;
  assign bus.rdata   = (bus.data_ok && rd_q[LATENCY-1]) ? data_q[LATENCY-1] : 32'h0;
endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three parameterisations driven one at a time
// and checked cycle by cycle against a queue-based reference model.
module tb_sram_like_slave;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  int          sel = 0;

  logic        dut_addr_ok, dut_data_ok;
  logic [31:0] dut_rdata;

  always #5 clk = ~clk;

  sram_like_slave_if if0 ();
  sram_like_slave_if if1 ();
  sram_like_slave_if if2 ();

  assign if0.req = req && (sel == 0);
  assign if1.req = req && (sel == 1);
  assign if2.req = req && (sel == 2);
  assign if0.wr = wr;    assign if1.wr = wr;    assign if2.wr = wr;
  assign if0.size = size; assign if1.size = size; assign if2.size = size;
  assign if0.wstrb = wstrb; assign if1.wstrb = wstrb; assign if2.wstrb = wstrb;
  assign if0.addr = addr; assign if1.addr = addr; assign if2.addr = addr;
  assign if0.wdata = wdata; assign if1.wdata = wdata; assign if2.wdata = wdata;

  sram_like_slave #(.ADDR_W(12), .LATENCY(2), .OUTSTANDING(2)) u0 (.clk(clk), .reset(reset), .bus(if0));
  sram_like_slave #(.ADDR_W(6),  .LATENCY(3), .OUTSTANDING(2)) u1 (.clk(clk), .reset(reset), .bus(if1));
  sram_like_slave #(.ADDR_W(6),  .LATENCY(1), .OUTSTANDING(1)) u2 (.clk(clk), .reset(reset), .bus(if2));

  always_comb begin
    dut_addr_ok = if0.addr_ok;
    dut_data_ok = if0.data_ok;
    dut_rdata   = if0.rdata;
    case (sel)
      1: begin dut_addr_ok = if1.addr_ok; dut_data_ok = if1.data_ok; dut_rdata = if1.rdata; end
      2: begin dut_addr_ok = if2.addr_ok; dut_data_ok = if2.data_ok; dut_rdata = if2.rdata; end
      default: ;
    endcase
  end

  // Reference model: a response is due L cycles after its acceptance cycle;
  // a request is outstanding until its response cycle begins.
  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rq [$];
  logic [31:0] mem_m [int];
  logic [31:0] addrs [$];
  int          L_m = 2, O_m = 2, AW_m = 12;
  int          cyc = 0;
  int          chk_cnt = 0, err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s sel=%0d cyc=%0d got %h expected %h", tag, sel, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit r, input bit w, input logic [3:0] st,
                      input logic [31:0] a, input logic [31:0] wd, output bit acc);
    int          pend, idx;
    bit          exp_ok, exp_dok;
    logic [31:0] exp_rd, word;
    rsp_t        e;
    @(negedge clk);
    reset = rst; req = r; wr = w; wstrb = st; addr = a; wdata = wd; size = 2'd2;
    #1;
    pend = 0;
    foreach (rq[i]) if (rq[i].due > cyc) pend++;
    exp_ok  = !rst && (pend < O_m);
    exp_dok = !rst && (rq.size() > 0) && (rq[0].due == cyc);
    exp_rd  = (exp_dok && rq[0].rd) ? rq[0].data : 32'h0;
    chk("addr_ok", {31'h0, dut_addr_ok}, {31'h0, exp_ok});
    chk("data_ok", {31'h0, dut_data_ok}, {31'h0, exp_dok});
    chk("rdata", dut_rdata, exp_rd);
    acc = r && exp_ok;
    @(posedge clk);
    if (rst) rq.delete();
    else begin
      if (exp_dok) void'(rq.pop_front());
      if (acc) begin
        idx  = int'((a >> 2) & ((32'd1 << AW_m) - 32'd1));
        word = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        if (w) begin
          for (int b = 0; b < 4; b++) if (st[b]) word[8*b +: 8] = wd[8*b +: 8];
          mem_m[idx] = word;
        end
        e.due  = cyc + L_m;
        e.rd   = !w;
        e.data = w ? 32'h0 : word;
        rq.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc);
  endtask

  task automatic issue(input bit w, input logic [3:0] st, input logic [31:0] a, input logic [31:0] wd);
    bit acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) step(1'b0, 1'b1, w, st, a, wd, acc);
    if (!acc) begin
      chk_cnt++;
      err_cnt++;
      $error("FAIL accept_timeout addr=%h got no acceptance, required one within 20 cycles", a);
    end
  endtask

  task automatic phase(input int s, input int aw, input int l, input int o);
    bit acc;
    sel = s; AW_m = aw; L_m = l; O_m = o;
    mem_m.delete();
    addrs.delete();
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc);
    idle(1);
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      issue(1'b1, 4'hF, base + 32'(4 * k), $urandom);
      addrs.push_back(base + 32'(4 * k));
    end
  endtask

  task automatic rand_ops(input int n);
    int          k;
    logic [31:0] a;
    logic [3:0]  st;
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(addrs.size() - 1);
      a  = addrs[k] | 32'($urandom_range(3)) | (32'($urandom_range(3)) << (AW_m + 2));
      st = 4'($urandom);
      case ($urandom_range(3))
        0:       idle(1);
        1:       issue(1'b1, st, a, $urandom);
        default: issue(1'b0, 4'h0, a, 32'h0);
      endcase
    end
    idle(L_m + 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout sel=%0d cyc=%0d", sel, cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    // LATENCY=2, OUTSTANDING=2, ADDR_W=12
    phase(0, 12, 2, 2);
    issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    idle(3);
    issue(1'b1, 4'hF, 32'h20, 32'h11223344);
    issue(1'b1, 4'b0100, 32'h20, 32'h00AB0000);
    issue(1'b0, 4'h0, 32'h20, 32'h0);
    idle(3);
    issue(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF);
    issue(1'b0, 4'h0, 32'h20, 32'h0);
    idle(3);
    issue(1'b1, 4'hF, 32'h4, 32'hCAFEF00D);
    issue(1'b0, 4'h0, 32'h4 | (32'h1 << 14), 32'h0);
    issue(1'b0, 4'h0, 32'h7, 32'h0);
    idle(3);
    issue(1'b1, 4'hF, 32'h30, 32'h5A5A1234);
    idle(3);
    issue(1'b0, 4'h0, 32'h30, 32'h0);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    begin
      bit acc;
      step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc);
      step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc);
    end
    idle(3);
    issue(1'b0, 4'h0, 32'h30, 32'h0);
    idle(3);
    addrs.push_back(32'h10); addrs.push_back(32'h20);
    addrs.push_back(32'h4);  addrs.push_back(32'h30);
    fill(32'h40, 8);
    rand_ops(150);

    // LATENCY=3, OUTSTANDING=2: addr_ok throttles the held request stream
    phase(1, 6, 3, 2);
    fill(32'h0, 6);
    idle(4);
    for (int k = 0; k < 6; k++) issue(1'b0, 4'h0, 32'(4 * k), 32'h0);
    idle(5);
    issue(1'b0, 4'h0, 32'h8 | (32'h1 << 8), 32'h0);
    idle(4);
    rand_ops(150);

    // LATENCY=1, OUTSTANDING=1: back-to-back acceptance
    phase(2, 6, 1, 1);
    fill(32'h0, 3);
    for (int k = 0; k < 3; k++) issue(1'b0, 4'h0, 32'(4 * k), 32'h0);
    idle(2);
    rand_ops(150);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
